trail_fb_arbiter: RTL
=====================

# trail_fb_arbiter

Write-port arbiter for the shared trail frame buffer (on-chip memory). It serialises burst writes from the blue trail writer and the red trail writer, and contains a clear engine that zero-fills the buffer on request (game start/restart). The block's registered outputs drive the frame buffer's single write port directly.

## Interface
Parameters:
- ADDR_W, 20, frame buffer address width
- DATA_W, 16, write data width
- CLEAR_DEPTH, 76800, number of words zeroed by a clear (addresses 0..CLEAR_DEPTH-1)
- MAX_BURST, 64, maximum words per requester burst before forced termination

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous, active-low reset
- clear_start  in  1  one-cycle pulse requesting a full-buffer clear
- clear_busy  out  1  clear pending or in progress
- clear_done  out  1  one-cycle pulse after the last clear write
- blue_req  in  1  blue burst request; held high until the last word is accepted
- blue_addr  in  ADDR_W  blue word address, valid with blue_req
- blue_data  in  DATA_W  blue word data
- blue_last  in  1  marks the final word of the blue burst
- blue_gnt  out  1  blue owns the port; word accepted on each cycle with blue_req & blue_gnt
- red_req, red_addr, red_data, red_last, red_gnt  same as blue, for red
- fb_we  out  1  frame buffer write enable
- fb_addr  out  ADDR_W  frame buffer write address
- fb_data  out  DATA_W  frame buffer write data
- burst_err  out  1  one-cycle pulse when a burst is force-terminated at MAX_BURST

## Operation
- States: IDLE, CLEAR, GNT_B, GNT_R.
- IDLE: if clear is pending, go to CLEAR. Otherwise, if a requester is active, grant it per the arbitration policy (see Configuration) and go to GNT_B or GNT_R. Otherwise stay in IDLE.
- GNT_x: x_gnt is high. Each cycle with x_req & x_gnt, the word is accepted and the burst counter increments.
  - Exit to IDLE on an accepted word with x_last.
  - Exit to IDLE if x_req drops; this is an abandoned burst, and no error is flagged.
  - Exit to IDLE when the counter reaches MAX_BURST; this pulses burst_err.
- CLEAR: clear counter runs 0..CLEAR_DEPTH-1, one zero word per cycle. After the last word, pulse clear_done and return to IDLE. Both grants are low throughout.
- Clear request handling:
  - clear_start sets a pending flag in any state; clear_busy rises on the next cycle.
  - An in-progress burst completes before CLEAR is entered. Clear is never interleaved within a burst.
  - clear_start while clear_busy is already high is ignored; it does not restart the clear.
- Simultaneous clear_start and new requests in IDLE: clear wins.
- The unselected requester waits with its req held; there is no timeout.
- Counter widths: the clear counter is ADDR_W bits, the burst counter is clog2(MAX_BURST)+1 bits. Addresses pass through unmodified; there is no wrap-around.

## Timing
- Reset values: state IDLE; all grants, fb_we, clear_busy, clear_done and burst_err are 0; fb_addr and fb_data are 0; pending flag and counters are 0; round-robin pointer favours blue.
- Grants are registered. A request seen in IDLE on cycle n gives gnt high on cycle n+1.
- Write latency is one cycle. A word accepted on cycle n appears on fb_we/fb_addr/fb_data on cycle n+1.
- gnt falls on the cycle after the terminating word. The earliest next grant is one cycle later, so there is a one-cycle bubble between bursts.
- Clear writes cover cycles c+1 .. c+CLEAR_DEPTH on the fb port, where c is the first CLEAR cycle.
  - clear_done is high on the cycle the last clear write is presented.
  - clear_busy falls on the following cycle.
- An asynchronous reset mid-burst or mid-clear drops fb_we immediately. Partial writes are not completed.

## Configuration
- TRAIL_ARB_RR_EN defined: round-robin arbitration. After a burst completes, the other requester has priority for the next grant.
- TRAIL_ARB_RR_EN undefined: fixed priority, blue over red. The round-robin pointer is not built.

## Test plan
- Reset, then clear_start pulse:
  - fb_we high for exactly 76800 consecutive cycles, addr 0..76799, data 0.
  - clear_done pulses on the addr-76799 cycle; clear_busy low the cycle after.
- Blue 4-word burst at addr 0x100..0x103 with last on the 4th word:
  - blue_gnt high for 4 cycles.
  - fb writes appear 1 cycle delayed with matching addr/data.
  - blue_gnt low the next cycle.
- blue_req and red_req rise on the same cycle, each with 2-word bursts, repeated twice:
  - RR_EN: grant order B, R, B, R.
  - Without RR_EN: B, B, R, R (blue re-requests immediately).
- clear_start during the 2nd word of a 4-word red burst: all 4 red words are written first, then the clear sequence begins; no interleaving.
- Red burst of 70 words without last, MAX_BURST=64: exactly 64 writes, burst_err pulses once, red_gnt drops.
- Reset_n low during the 3rd clear write: fb_we is 0 asynchronously; after release, state is IDLE and clear_busy is 0.

Source files
------------

// File: rtl/trail_fb_arbiter.sv
// trail_fb_arbiter: single write port arbiter for the shared trail frame buffer.
// Serialises blue/red trail writer bursts and zero-fills the buffer on request.
// Optional build macro TRAIL_ARB_RR_EN selects round-robin arbitration; when it
// is undefined, blue has fixed priority over red.
module trail_fb_arbiter #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned CLEAR_DEPTH = 76800,
    parameter int unsigned MAX_BURST   = 64
) (
    input  logic              Clk,
    input  logic              Reset_n,

    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,

    input  logic              blue_req,
    input  logic [ADDR_W-1:0] blue_addr,
    input  logic [DATA_W-1:0] blue_data,
    input  logic              blue_last,
    output logic              blue_gnt,

    input  logic              red_req,
    input  logic [ADDR_W-1:0] red_addr,
    input  logic [DATA_W-1:0] red_data,
    input  logic              red_last,
    output logic              red_gnt,

    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_data,
    output logic              burst_err
);

    localparam int unsigned BCNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {StIdle, StClear, StGntB, StGntR} state_e;

    state_e              state_q, state_d;
    logic                pending_q, pending_d;
    logic                clear_busy_q, clear_busy_d;
    logic                clear_done_q, clear_done_d;
    logic                burst_err_q, burst_err_d;
    logic                blue_gnt_q, blue_gnt_d;
    logic                red_gnt_q, red_gnt_d;
    logic                fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0]   fb_data_q, fb_data_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;

    logic start_acc;
    logic clr_req;
    logic clr_last;
    logic burst_cap;
    logic blue_acc;
    logic red_acc;
    logic blue_pri;

    // A clear request arriving while one is already pending/running is dropped.
    assign start_acc = clear_start & ~clear_busy_q;
    // Same-cycle clear_start is visible to IDLE so it beats new requests.
    assign clr_req   = pending_q | start_acc;
    assign clr_last  = (clr_cnt_q == ADDR_W'(CLEAR_DEPTH - 1));
    // Current word is the MAX_BURST-th of the burst.
    assign burst_cap = (bcnt_q == BCNT_W'(MAX_BURST - 1));
    assign blue_acc  = blue_req & blue_gnt_q;
    assign red_acc   = red_req & red_gnt_q;

`ifdef TRAIL_ARB_RR_EN
    logic prio_red_q, prio_red_d;

    assign blue_pri = ~prio_red_q;

    // Hand priority to the other side whenever a burst is granted.
    always_comb begin
        prio_red_d = prio_red_q;
        if (state_q == StIdle && state_d == StGntB) prio_red_d = 1'b1;
        if (state_q == StIdle && state_d == StGntR) prio_red_d = 1'b0;
    end

    // Round-robin pointer register; reset favours blue.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) prio_red_q <= 1'b0;
        else          prio_red_q <= prio_red_d;
    end
`else
    assign blue_pri = 1'b1;
`endif

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Next-state: clear first, then arbitration; bursts run to completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req)                                  state_d = StClear;
                else if (blue_req && (blue_pri || !red_req))  state_d = StGntB;
                else if (red_req)                             state_d = StGntR;
            end
            StClear: begin
                if (clr_last) state_d = StIdle;
            end
            StGntB: begin
                if (!blue_acc || blue_last || burst_cap) state_d = StIdle;
            end
            StGntR: begin
                if (!red_acc || red_last || burst_cap) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next values; everything leaves the block registered.
    always_comb begin
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        clear_done_d = 1'b0;
        burst_err_d  = 1'b0;
        clr_cnt_d    = clr_cnt_q;
        bcnt_d       = bcnt_q;
        pending_d    = pending_q | start_acc;
        // Busy holds through the clear_done cycle, then falls.
        clear_busy_d = (clear_busy_q & ~clear_done_q) | start_acc;
        blue_gnt_d   = (state_d == StGntB);
        red_gnt_d    = (state_d == StGntR);
        unique case (state_q)
            StIdle: begin
                bcnt_d    = '0;
                clr_cnt_d = '0;
                if (clr_req) pending_d = 1'b0;
            end
            StClear: begin
                fb_we_d   = 1'b1;
                fb_addr_d = clr_cnt_q;
                fb_data_d = '0;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_last) clear_done_d = 1'b1;
            end
            StGntB: begin
                if (blue_acc) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = blue_addr;
                    fb_data_d = blue_data;
                    bcnt_d    = bcnt_q + BCNT_W'(1);
                    if (!blue_last && burst_cap) burst_err_d = 1'b1;
                end
            end
            StGntR: begin
                if (red_acc) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = red_addr;
                    fb_data_d = red_data;
                    bcnt_d    = bcnt_q + BCNT_W'(1);
                    if (!red_last && burst_cap) burst_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output, counter and clear-flag registers; reset drops fb_we at once.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            clear_done_q <= 1'b0;
            clear_busy_q <= 1'b0;
            burst_err_q  <= 1'b0;
            pending_q    <= 1'b0;
            clr_cnt_q    <= '0;
            bcnt_q       <= '0;
            blue_gnt_q   <= 1'b0;
            red_gnt_q    <= 1'b0;
        end else begin
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            clear_done_q <= clear_done_d;
            clear_busy_q <= clear_busy_d;
            burst_err_q  <= burst_err_d;
            pending_q    <= pending_d;
            clr_cnt_q    <= clr_cnt_d;
            bcnt_q       <= bcnt_d;
            blue_gnt_q   <= blue_gnt_d;
            red_gnt_q    <= red_gnt_d;
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign clear_done = clear_done_q;
    assign clear_busy = clear_busy_q;
    assign burst_err  = burst_err_q;
    assign blue_gnt   = blue_gnt_q;
    assign red_gnt    = red_gnt_q;

endmodule
